// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences ALU, memory, IR and PC across the steps of each instruction.
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to trap on unrecognised opcodes (sticky until reset).
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_FUNCT = 4'b1000;

    logic [3:0] r_state;
    logic [3:0] w_nextState;
    logic       r_isStore;

    // Opcode is only trusted in DECODE, so lw/sw is remembered for the MEMADR branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_isStore <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE)
                r_isStore <= (Opcode == OP_SW);
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:  w_nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_nextState = S_MEMADR;
                    OP_RTYPE:     w_nextState = S_EXEC;
                    OP_BEQ:       w_nextState = S_BRANCH;
                    OP_J:         w_nextState = S_JUMP;
                    OP_ADDI:      w_nextState = S_ADDIEX;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      w_nextState = S_TRAP;
`else
                    default:      w_nextState = S_ADDIEX;
`endif
                endcase
            end
            S_MEMADR: w_nextState = r_isStore ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_nextState = S_ALUWB;
            S_ADDIEX: w_nextState = S_ADDIWB;
            S_TRAP:   w_nextState = S_TRAP;
            default:  w_nextState = S_FETCH;
        endcase
    end

    // Reset blanks every output immediately, so an abandoned store never strobes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 4'b0000;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALU_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = ALU_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemToReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCSource    = 2'b01;
                    PCWriteCond = 1'b1;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCSource   = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? 4'd0 : r_state;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign illegal_op = !reset && (r_state == S_TRAP);
`else
    assign illegal_op = 1'b0;
`endif

endmodule
